// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: A - B - BorrowIn, one 4-bit CLA slice per clock, LSB first.
// Optional SUBTRACTOR_OVERFLOW_EN adds a registered signed-overflow flag (OutputOverflow).
module nibble_serial_subtractor #(
  parameter int Width = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InputValid,
  output logic             InputReady,
  input  logic [Width-1:0] InputA,
  input  logic [Width-1:0] InputB,
  input  logic             InputBorrow,
  output logic [Width-1:0] Output,
  output logic             OutputBorrow,
  output logic             OutputZero,
  output logic             OutputValid,
  input  logic             OutputReady
`ifdef SUBTRACTOR_OVERFLOW_EN
  , output logic           OutputOverflow
`endif
);
  localparam int N  = Width / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [Width-1:0] a_sh, nb_sh, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb;
  logic [3:0]       slice_sum;
  logic             slice_cout, accept, last;

  // 4-bit carry-lookahead adder; carries are flattened sum-of-products of g/p.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g = x & y;
    p = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign {slice_cout, slice_sum} = cla4(a_sh[3:0], nb_sh[3:0], carry);
  // Result fills from the top; after N slices the LSB nibble has shifted into place.
  assign res_nxt = Width'({slice_sum, Output} >> 4);
  assign last    = (cnt == CW'(N - 1));
  assign accept  = InputValid && InputReady;

  always_comb begin
    state_nxt  = state;
    InputReady = (state == IDLE) && !Reset;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (OutputReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      nb_sh        <= '0;
      carry        <= 1'b0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      Output       <= '0;
      OutputBorrow <= 1'b0;
      OutputZero   <= 1'b0;
      OutputValid  <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
      OutputOverflow <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          a_sh         <= InputA;
          nb_sh        <= ~InputB;
          carry        <= ~InputBorrow;
          a_msb        <= InputA[Width-1];
          b_msb        <= InputB[Width-1];
          cnt          <= '0;
          Output       <= '0;
          OutputBorrow <= 1'b0;
          OutputZero   <= 1'b0;
        end
        RUN: begin
          a_sh   <= a_sh >> 4;
          nb_sh  <= nb_sh >> 4;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          Output <= res_nxt;
          if (last) begin
            OutputBorrow <= ~slice_cout;
            OutputZero   <= (res_nxt == '0);
            OutputValid  <= 1'b1;
`ifdef SUBTRACTOR_OVERFLOW_EN
            OutputOverflow <= (a_msb != b_msb) && (res_nxt[Width-1] != a_msb);
`endif
          end
        end
        DONE: if (OutputReady) begin
          OutputValid <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
          OutputOverflow <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef SUBTRACTOR_OVERFLOW_EN
  logic unused_msbs;
  assign unused_msbs = a_msb ^ b_msb;
`endif
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (Width = 16).
module tb_nibble_serial_subtractor;
  localparam int W = 16;

  logic         Clock = 0, Reset = 1, InputValid = 0, InputBorrow = 0, OutputReady = 0;
  logic [W-1:0] InputA = '0, InputB = '0, Output;
  logic         InputReady, OutputBorrow, OutputZero, OutputValid;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic         OutputOverflow;
`endif

  nibble_serial_subtractor #(.Width(W)) dut (
    .Clock(Clock), .Reset(Reset), .InputValid(InputValid), .InputReady(InputReady),
    .InputA(InputA), .InputB(InputB), .InputBorrow(InputBorrow), .Output(Output),
    .OutputBorrow(OutputBorrow), .OutputZero(OutputZero), .OutputValid(OutputValid),
    .OutputReady(OutputReady)
`ifdef SUBTRACTOR_OVERFLOW_EN
    , .OutputOverflow(OutputOverflow)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [W-1:0] d; logic b, z, ov; } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  // Present operands once InputReady is seen, push the reference result, accept at the next edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    exp_t e;
    int n = 0;
    while (!InputReady && n < 20) begin tick(); n++; end
    checks++;
    if (!InputReady) $display("FAIL accept_wait InputReady got 0 required 1");
    else passed++;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.d  = full[W-1:0];
    e.b  = full[W];
    e.z  = (full[W-1:0] == '0);
    e.ov = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    sb.push_back(e);
    InputA = a; InputB = b; InputBorrow = bin; InputValid = 1;
    tick();
    InputValid = 0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!OutputValid && cyc < 20) begin tick(); cyc++; end
    if (!OutputValid) cyc = -1;
  endtask

  task automatic handshake();
    OutputReady = 1;
    tick();
    OutputReady = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    tick(); tick();
    checks++;
    if (InputReady !== 1'b0 || OutputValid !== 1'b0 || Output !== '0 || OutputBorrow !== 1'b0 || OutputZero !== 1'b0)
      $display("FAIL reset_state got rdy=%b vld=%b out=%h bor=%b z=%b required 0 0 0000 0 0",
               InputReady, OutputValid, Output, OutputBorrow, OutputZero);
    else passed++;
`ifdef SUBTRACTOR_OVERFLOW_EN
    checks++;
    if (OutputOverflow !== 1'b0) $display("FAIL reset_ovf got %b required 0", OutputOverflow);
    else passed++;
`endif
    Reset = 0;
    tick();
    checks++;
    if (InputReady !== 1'b1) $display("FAIL reset_release_ready got %b required 1", InputReady);
    else passed++;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555, 16'h0000};
    logic [W-1:0] tb_ [5] = '{16'h0234, 16'h0001, 16'h0001, 16'h5554, 16'h0000};
    logic         tbin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      accept_op(ta[i], tb_[i], tbin[i]);
      wait_valid(cyc);
      checks++;
      if (cyc !== 4) $display("FAIL basic%0d_latency got %0d required 4", i, cyc);
      else passed++;
      e = sb.pop_front();
      checks++;
      if (Output !== e.d || OutputBorrow !== e.b || OutputZero !== e.z)
        $display("FAIL basic%0d_result got %h/%b/%b required %h/%b/%b",
                 i, Output, OutputBorrow, OutputZero, e.d, e.b, e.z);
      else passed++;
`ifdef SUBTRACTOR_OVERFLOW_EN
      checks++;
      if (OutputOverflow !== e.ov) $display("FAIL basic%0d_ovf got %b required %b", i, OutputOverflow, e.ov);
      else passed++;
`endif
      handshake();
      checks++;
      if (InputReady !== 1'b1 || OutputValid !== 1'b0)
        $display("FAIL basic%0d_return_idle got rdy=%b vld=%b required 1 0", i, InputReady, OutputValid);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    accept_op(16'h9ABC, 16'h1234, 1'b0);
    wait_valid(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc < 0 || Output !== e.d) $display("FAIL bp_result got %h required %h", Output, e.d);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      InputValid = ~i[0];
      InputA = 16'($urandom); InputB = 16'($urandom); InputBorrow = i[1];
      tick();
      checks++;
      if (Output !== e.d || InputReady !== 1'b0 || OutputValid !== 1'b1 || OutputBorrow !== e.b)
        $display("FAIL bp_hold%0d got out=%h rdy=%b vld=%b required %h 0 1", i, Output, InputReady, OutputValid, e.d);
      else passed++;
    end
    InputValid = 0;
    handshake();
    checks++;
    if (InputReady !== 1'b1) $display("FAIL bp_ready_after got %b required 1", InputReady);
    else passed++;
    accept_op(16'h0F00, 16'h00F1, 1'b1);
    wait_valid(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 4 || Output !== e.d || OutputBorrow !== e.b)
      $display("FAIL bp_next got %h/%b cyc=%0d required %h/%b cyc=4", Output, OutputBorrow, cyc, e.d, e.b);
    else passed++;
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic seen = 0;
    exp_t e;
    while (!InputReady) tick();
    InputA = 16'hFFFF; InputB = 16'h0001; InputBorrow = 0; InputValid = 1;
    tick();
    InputValid = 0;
    tick(); tick();
    Reset = 1;
    #1;
    checks++;
    if (InputReady !== 1'b0) $display("FAIL mid_reset_ready got %b required 0", InputReady);
    else passed++;
    tick();
    Reset = 0;
    #1;
    checks++;
    if (Output !== '0 || OutputBorrow !== 1'b0 || OutputZero !== 1'b0 || OutputValid !== 1'b0 || InputReady !== 1'b1)
      $display("FAIL mid_reset_outputs got out=%h bor=%b z=%b vld=%b rdy=%b required 0000 0 0 0 1",
               Output, OutputBorrow, OutputZero, OutputValid, InputReady);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      if (OutputValid) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_no_valid got 1 required 0");
    else passed++;
    accept_op(16'h0003, 16'h0001, 1'b0);
    wait_valid(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 4 || Output !== 16'h0002 || Output !== e.d || OutputBorrow !== 1'b0)
      $display("FAIL after_reset_op got %h cyc=%0d required 0002 cyc=4", Output, cyc);
    else passed++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
